// File: rtl/gfx_pkg.sv
// Shared definitions for the sprite compositor.
// Holds the mode encodings and the default geometry.
package gfx_pkg;

    localparam int N_LAYERS_DEF = 4;
    localparam int COLOR_W_DEF  = 8;
    localparam int COORD_W_DEF  = 16;

    typedef enum logic [1:0] {
        MODE_PRIO  = 2'd0,
        MODE_BLEND = 2'd1,
        MODE_DEBUG = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // The reserved encoding falls back to plain priority.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        return (raw == MODE_RSVD) ? MODE_PRIO : mode_e'(raw);
    endfunction

endpackage

// File: rtl/gfx_if.sv
// Pixel-stream bundle feeding the compositor and carrying its result.
// The master side drives the video timing and layer data.
interface gfx_if
    import gfx_pkg::*;
#(
    parameter int N_LAYERS = N_LAYERS_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int COORD_W  = COORD_W_DEF
) ();

    logic [COORD_W-1:0]            x;
    logic [COORD_W-1:0]            y;
    logic                          de;
    logic                          v_sync;
    logic [3*COLOR_W-1:0]          bg_rgb;
    logic [N_LAYERS*3*COLOR_W-1:0] layer_rgb;
    logic [N_LAYERS-1:0]           layer_hit;
    logic [N_LAYERS-1:0]           layer_en;
    logic [1:0]                    mode;

    logic [COLOR_W-1:0]            red;
    logic [COLOR_W-1:0]            green;
    logic [COLOR_W-1:0]            blue;
    logic [COORD_W-1:0]            out_x;
    logic [COORD_W-1:0]            out_y;
    logic                          out_de;
    logic [N_LAYERS-1:0]           collide;
    logic                          frame_tick;

    modport master (
        output x, y, de, v_sync, bg_rgb, layer_rgb,
        output layer_hit, layer_en, mode,
        input  red, green, blue, out_x, out_y, out_de,
        input  collide, frame_tick
    );

    modport slave (
        input  x, y, de, v_sync, bg_rgb, layer_rgb,
        input  layer_hit, layer_en, mode,
        output red, green, blue, out_x, out_y, out_de,
        output collide, frame_tick
    );

endinterface

// File: rtl/gfx_prio_enc.sv
// Finds the lowest-index and next-lowest-index visible layers.
// Purely combinational.
module gfx_prio_enc
    import gfx_pkg::*;
#(
    parameter int N_LAYERS = N_LAYERS_DEF
) (
    input  logic [N_LAYERS-1:0]         vis,
    output logic                        top_valid,
    output logic [$clog2(N_LAYERS)-1:0] top_idx,
    output logic                        sec_valid,
    output logic [$clog2(N_LAYERS)-1:0] sec_idx
);

    localparam int IDX_W = $clog2(N_LAYERS);

    // Walk downwards so each new hit pushes the old winner into second place.
    always_comb begin
        top_valid = 1'b0;
        top_idx   = '0;
        sec_valid = 1'b0;
        sec_idx   = '0;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (vis[k]) begin
                sec_valid = top_valid;
                sec_idx   = top_idx;
                top_valid = 1'b1;
                top_idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/gfx_compositor.sv
// Two-stage sprite compositor with frame-latched controls
// and per-frame layer collision reporting.
module gfx_compositor
    import gfx_pkg::*;
#(
    parameter int N_LAYERS = N_LAYERS_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [COORD_W-1:0]            i_x,
    input  logic [COORD_W-1:0]            i_y,
    input  logic                          i_de,
    input  logic                          i_v_sync,
    input  logic [3*COLOR_W-1:0]          i_bg_rgb,
    input  logic [N_LAYERS*3*COLOR_W-1:0] i_layer_rgb,
    input  logic [N_LAYERS-1:0]           i_layer_hit,
    input  logic [N_LAYERS-1:0]           i_layer_en,
    input  logic [1:0]                    i_mode,
    output logic [COLOR_W-1:0]            o_red,
    output logic [COLOR_W-1:0]            o_green,
    output logic [COLOR_W-1:0]            o_blue,
    output logic [COORD_W-1:0]            o_x,
    output logic [COORD_W-1:0]            o_y,
    output logic                          o_de,
    output logic [N_LAYERS-1:0]           o_collide,
    output logic                          o_frame_tick
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int IDX_W = $clog2(N_LAYERS);

    logic                vs_prev;
    logic                vs_edge;
    logic [N_LAYERS-1:0] shadow_en;
    mode_e               shadow_mode;
    logic [N_LAYERS-1:0] vis;
    logic [N_LAYERS-1:0] coll_now;
    logic [N_LAYERS-1:0] coll_acc;

    logic                top_valid;
    logic                sec_valid;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    sec_idx;
    logic [PIX_W-1:0]    top_rgb;
    logic [PIX_W-1:0]    sec_rgb;

    logic                s1_de;
    logic [COORD_W-1:0]  s1_x;
    logic [COORD_W-1:0]  s1_y;
    logic [PIX_W-1:0]    s1_bg;
    logic [PIX_W-1:0]    s1_top;
    logic [PIX_W-1:0]    s1_sec;
    logic                s1_top_v;
    logic                s1_sec_v;
    mode_e               s1_mode;
    logic [PIX_W-1:0]    pix;

    assign vs_edge = i_v_sync & ~vs_prev;
    assign vis     = i_layer_hit & shadow_en;

    gfx_prio_enc #(
        .N_LAYERS (N_LAYERS)
    ) u_prio (
        .vis       (vis),
        .top_valid (top_valid),
        .top_idx   (top_idx),
        .sec_valid (sec_valid),
        .sec_idx   (sec_idx)
    );

    // A second visible layer means every visible layer overlaps another.
    assign coll_now = (i_de && sec_valid) ? vis : '0;
    assign top_rgb  = i_layer_rgb[int'(top_idx) * PIX_W +: PIX_W];
    assign sec_rgb  = i_layer_rgb[int'(sec_idx) * PIX_W +: PIX_W];

    function automatic logic [PIX_W-1:0] avg_rgb(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        logic [COLOR_W:0] sum;
        avg_rgb = '0;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, a[c*COLOR_W +: COLOR_W]}
                + {1'b0, b[c*COLOR_W +: COLOR_W]};
            avg_rgb[c*COLOR_W +: COLOR_W] = sum[COLOR_W:1];
        end
    endfunction

    always_comb begin
        pix = s1_bg;
        if (s1_top_v) begin
            case (s1_mode)
                MODE_BLEND:
                    pix = avg_rgb(s1_top, s1_sec_v ? s1_sec : s1_bg);
                MODE_DEBUG:
                    pix = {{COLOR_W{s1_sec_v}},
                           {COLOR_W{~s1_sec_v}},
                           {COLOR_W{1'b0}}};
                default:
                    pix = s1_top;
            endcase
        end
    end

    // Frame-level control: sync history, shadows, collision bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_prev      <= 1'b0;
            shadow_en    <= '1;
            shadow_mode  <= MODE_PRIO;
            coll_acc     <= '0;
            o_collide    <= '0;
            o_frame_tick <= 1'b0;
        end else begin
            vs_prev      <= i_v_sync;
            o_frame_tick <= vs_edge;
            if (vs_edge) begin
                shadow_en   <= i_layer_en;
                shadow_mode <= decode_mode(i_mode);
                o_collide   <= coll_acc | coll_now;
                coll_acc    <= '0;
            end else begin
                coll_acc    <= coll_acc | coll_now;
            end
        end
    end

    // Pixel pipeline: stage 1 captures selection, stage 2 the colour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_de    <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_bg    <= '0;
            s1_top   <= '0;
            s1_sec   <= '0;
            s1_top_v <= 1'b0;
            s1_sec_v <= 1'b0;
            s1_mode  <= MODE_PRIO;
            o_de     <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            o_red    <= '0;
            o_green  <= '0;
            o_blue   <= '0;
        end else begin
            s1_de    <= i_de;
            s1_x     <= i_x;
            s1_y     <= i_y;
            s1_bg    <= i_bg_rgb;
            s1_top   <= top_rgb;
            s1_sec   <= sec_rgb;
            s1_top_v <= top_valid;
            s1_sec_v <= sec_valid;
            s1_mode  <= shadow_mode;
            o_de     <= s1_de;
            o_x      <= s1_x;
            o_y      <= s1_y;
            o_red    <= s1_de ? pix[3*COLOR_W-1:2*COLOR_W] : '0;
            o_green  <= s1_de ? pix[2*COLOR_W-1:COLOR_W]   : '0;
            o_blue   <= s1_de ? pix[COLOR_W-1:0]           : '0;
        end
    end

endmodule

// File: tb/tb_gfx_compositor.sv
// Directed scoreboard bench for gfx_compositor.
// Expected pixels are queued at drive time and popped two cycles later.
module tb_gfx_compositor;
    import gfx_pkg::*;

    localparam int N = 4;
    localparam int C = 8;
    localparam int W = 16;

    typedef struct packed {
        logic        de;
        logic [15:0] x;
        logic [15:0] y;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gfx_if #(.N_LAYERS(N), .COLOR_W(C), .COORD_W(W)) bus ();

    gfx_compositor #(
        .N_LAYERS (N),
        .COLOR_W  (C),
        .COORD_W  (W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_x          (bus.x),
        .i_y          (bus.y),
        .i_de         (bus.de),
        .i_v_sync     (bus.v_sync),
        .i_bg_rgb     (bus.bg_rgb),
        .i_layer_rgb  (bus.layer_rgb),
        .i_layer_hit  (bus.layer_hit),
        .i_layer_en   (bus.layer_en),
        .i_mode       (bus.mode),
        .o_red        (bus.red),
        .o_green      (bus.green),
        .o_blue       (bus.blue),
        .o_x          (bus.out_x),
        .o_y          (bus.out_y),
        .o_de         (bus.out_de),
        .o_collide    (bus.collide),
        .o_frame_tick (bus.frame_tick)
    );

    int tests = 0;
    int fails = 0;

    exp_t        q[$];
    logic [23:0] lrgb[4];
    logic [23:0] bg;
    logic [3:0]  m_en;
    logic [1:0]  m_mode;
    logic        m_vs_prev;
    logic [3:0]  m_acc;
    logic [3:0]  m_col;
    logic        m_tick;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input logic [3:0] vis,
                                              input logic [1:0] mode);
        int n = 0;
        int t = -1;
        int s = -1;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] r;
        for (int k = 0; k < 4; k++) begin
            if (vis[k]) begin
                n++;
                if (t < 0) t = k;
                else if (s < 0) s = k;
            end
        end
        if (n == 0) return bg;
        a = lrgb[t];
        if (mode == 2'd1) begin
            b = (s >= 0) ? lrgb[s] : bg;
            r[23:16] = 8'((int'(a[23:16]) + int'(b[23:16])) / 2);
            r[15:8]  = 8'((int'(a[15:8])  + int'(b[15:8]))  / 2);
            r[7:0]   = 8'((int'(a[7:0])   + int'(b[7:0]))   / 2);
            return r;
        end
        if (mode == 2'd2) return (n >= 2) ? 24'hFF0000 : 24'h00FF00;
        return a;
    endfunction

    task automatic model_reset();
        m_en      = 4'hF;
        m_mode    = 2'd0;
        m_vs_prev = 1'b0;
        m_acc     = 4'h0;
        m_col     = 4'h0;
        m_tick    = 1'b0;
        q.delete();
    endtask

    task automatic cycle(input logic [15:0] x, input logic [15:0] y,
                         input logic de, input logic vs,
                         input logic [3:0] hit, input logic [3:0] en,
                         input logic [1:0] mode);
        logic [3:0] vis;
        logic [3:0] now;
        logic       edge_c;
        int         n;
        exp_t       e;
        exp_t       got;
        bus.x         = x;
        bus.y         = y;
        bus.de        = de;
        bus.v_sync    = vs;
        bus.layer_hit = hit;
        bus.layer_en  = en;
        bus.mode      = mode;
        bus.bg_rgb    = bg;
        bus.layer_rgb = {lrgb[3], lrgb[2], lrgb[1], lrgb[0]};
        vis = hit & m_en;
        n = $countones(vis);
        e.de  = de;
        e.x   = x;
        e.y   = y;
        e.rgb = de ? model_pix(vis, m_mode) : 24'h0;
        q.push_back(e);
        edge_c = vs & ~m_vs_prev;
        now = (de && n >= 2) ? vis : 4'h0;
        @(posedge clk);
        #1;
        m_vs_prev = vs;
        if (edge_c) begin
            m_col  = m_acc | now;
            m_acc  = 4'h0;
            m_tick = 1'b1;
            m_en   = en;
            m_mode = mode;
        end else begin
            m_acc  = m_acc | now;
            m_tick = 1'b0;
        end
        chk("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
        chk("collide", 32'(bus.collide), 32'(m_col));
        if (q.size() == 2) begin
            got = q.pop_front();
            chk("out_de", 32'(bus.out_de), 32'(got.de));
            chk("out_x", 32'(bus.out_x), 32'(got.x));
            chk("out_y", 32'(bus.out_y), 32'(got.y));
            chk("out_rgb", {8'h0, bus.red, bus.green, bus.blue},
                32'(got.rgb));
        end
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rgb", {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
        chk("rst_xy", {bus.out_x, bus.out_y}, 32'h0);
        chk("rst_de", 32'(bus.out_de), 32'h0);
        chk("rst_collide", 32'(bus.collide), 32'h0);
        chk("rst_tick", 32'(bus.frame_tick), 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst           = 1'b1;
        bus.x         = '0;
        bus.y         = '0;
        bus.de        = 1'b0;
        bus.v_sync    = 1'b0;
        bus.layer_hit = '0;
        bus.layer_en  = 4'hF;
        bus.mode      = 2'd0;
        bg      = 24'h0000FF;
        lrgb[0] = 24'hFF0000;
        lrgb[1] = 24'hFE0000;
        lrgb[2] = 24'h00FF00;
        lrgb[3] = 24'h020000;
        bus.bg_rgb    = bg;
        bus.layer_rgb = {lrgb[3], lrgb[2], lrgb[1], lrgb[0]};
        reset_cycle();
        reset_cycle();

        // Frame A: priority mode, layers 0 and 2 overlap
        cycle(0, 0, 0, 1, 4'b0000, 4'hF, 0);
        cycle(0, 0, 0, 0, 4'b0000, 4'hF, 0);
        cycle(10, 20, 1, 0, 4'b0101, 4'hF, 0);
        cycle(11, 20, 1, 0, 4'b0000, 4'hF, 0);
        chk("prio_red", 32'(bus.red), 32'hFF);
        chk("prio_green", 32'(bus.green), 32'h00);
        chk("prio_x", 32'(bus.out_x), 32'd10);
        chk("prio_y", 32'(bus.out_y), 32'd20);
        cycle(12, 20, 1, 0, 4'b1000, 4'hF, 0);
        cycle(13, 20, 0, 0, 4'b1010, 4'hF, 0);
        cycle(14, 20, 1, 0, 4'b0010, 4'hF, 1);

        // Frame B: blend mode; enable change requested mid-frame
        cycle(0, 0, 0, 1, 4'b0000, 4'hF, 1);
        chk("edge_a_collide", 32'(bus.collide), 32'b0101);
        cycle(0, 0, 0, 1, 4'b0000, 4'hF, 1);
        cycle(1, 1, 1, 0, 4'b1010, 4'hF, 1);
        cycle(2, 1, 1, 0, 4'b0010, 4'b1110, 1);
        chk("blend_rgb", {8'h0, bus.red, bus.green, bus.blue}, 32'h800000);
        cycle(3, 1, 1, 0, 4'b0001, 4'b1110, 1);
        cycle(4, 1, 1, 0, 4'b0000, 4'b1110, 1);
        chk("en_hold_rgb", {8'h0, bus.red, bus.green, bus.blue},
            32'h7F007F);

        // Frame C: hit-debug, layer 0 now disabled
        cycle(0, 0, 0, 1, 4'b0000, 4'b1110, 2);
        chk("edge_b_collide", 32'(bus.collide), 32'b1010);
        chk("edge_b_tick", 32'(bus.frame_tick), 32'h1);
        cycle(0, 0, 0, 0, 4'b0000, 4'b1110, 2);
        cycle(5, 2, 1, 0, 4'b0011, 4'b1110, 2);
        cycle(6, 2, 1, 0, 4'b0110, 4'b1110, 2);
        cycle(7, 2, 1, 0, 4'b0001, 4'b1110, 2);
        cycle(8, 2, 1, 0, 4'b0000, 4'b1110, 2);
        chk("en_skip_rgb", {8'h0, bus.red, bus.green, bus.blue},
            32'h0000FF);

        // Collision on the edge cycle belongs to the closing frame
        cycle(0, 0, 1, 1, 4'b1100, 4'hF, 0);
        chk("edge_c_collide", 32'(bus.collide), 32'b1110);
        cycle(0, 0, 0, 0, 4'b0000, 4'hF, 0);
        cycle(9, 3, 1, 0, 4'b0100, 4'hF, 0);
        cycle(0, 0, 0, 1, 4'b0000, 4'b1110, 3);
        chk("edge_d_collide", 32'(bus.collide), 32'b0000);

        // Reserved mode, then reset mid-line
        cycle(0, 0, 0, 0, 4'b0000, 4'b1110, 3);
        cycle(20, 4, 1, 0, 4'b0011, 4'b1110, 3);
        cycle(21, 4, 1, 0, 4'b0001, 4'b1110, 3);
        reset_cycle();
        cycle(22, 4, 1, 0, 4'b0001, 4'b1110, 0);
        cycle(23, 4, 1, 0, 4'b0000, 4'b1110, 0);
        chk("post_rst_red", 32'(bus.red), 32'hFF);
        chk("post_rst_x", 32'(bus.out_x), 32'd22);
        cycle(0, 0, 0, 0, 4'b0000, 4'b1110, 0);
        cycle(0, 0, 0, 0, 4'b0000, 4'b1110, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
